// File: rtl/cut_test_pkg.sv
// Shared types and golden reference for the 3-in/4-out CUT response checker.
package cut_test_pkg;

    localparam int unsigned VEC_W  = 3;
    localparam int unsigned RESP_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        SETTLE,
        SAMPLE,
        DONE
    } cut_state_e;

    typedef struct packed {
        logic [VEC_W-1:0]  vec;
        logic [RESP_W-1:0] resp;
    } fail_rec_t;

    // Expected CUT response {H,G,F,E} for inputs {A,B,C}.
    function automatic logic [RESP_W-1:0] golden_resp(input logic [VEC_W-1:0] vec);
        logic a;
        logic b;
        logic c;
        a = vec[2];
        b = vec[1];
        c = vec[0];
        return {a & b & c, ~c, a | c, a & b};
    endfunction

endpackage

// File: rtl/cut_golden_model.sv
// Combinational golden model of the CUT: input vector to expected response.
module cut_golden_model
    import cut_test_pkg::*;
(
    input  logic [VEC_W-1:0]  vec_i,
    output logic [RESP_W-1:0] exp_resp_o
);

    assign exp_resp_o = golden_resp(vec_i);

endmodule

// File: rtl/cut_response_checker.sv
// Sweeps all CUT input vectors, samples the responses and flags trojan-like mismatches.
// Optional CUT_STOP_ON_FAIL_EN: end the run at the first mismatching sample.
module cut_response_checker
    import cut_test_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned PASSES        = 1,
    parameter int unsigned CNT_W         = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [VEC_W-1:0]  vec_o,
    input  logic [RESP_W-1:0] resp_i,
    output logic              busy,
    output logic              done,
    output logic              trojan_flag,
    output logic [CNT_W-1:0]  mismatch_cnt,
    output logic [VEC_W-1:0]  first_fail_vec,
    output logic [RESP_W-1:0] first_fail_resp
);

    localparam int unsigned SET_W     = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned SET_LAST  = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;
    localparam int unsigned PASS_W    = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam int unsigned PASS_LAST = (PASSES > 0) ? PASSES - 1 : 0;
    localparam logic [VEC_W-1:0] LAST_IDX = '1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    cut_state_e         state_q;
    logic [VEC_W-1:0]   vec_q;
    logic [VEC_W-1:0]   idx_q;
    logic [PASS_W-1:0]  pass_q;
    logic [SET_W-1:0]   set_cnt_q;
    logic               busy_q;
    logic               done_q;
    logic               flag_q;
    logic [CNT_W-1:0]   cnt_q;
    fail_rec_t          ff_q;

    logic [RESP_W-1:0]  exp_resp_c;
    logic               mismatch_c;
    logic               last_c;
    logic               go_done_c;

    cut_golden_model u_golden (
        .vec_i      (vec_q),
        .exp_resp_o (exp_resp_c)
    );

    assign mismatch_c = (resp_i != exp_resp_c);
    assign last_c     = (idx_q == LAST_IDX) && (pass_q == PASS_W'(PASS_LAST));

`ifdef CUT_STOP_ON_FAIL_EN
    assign go_done_c = last_c | mismatch_c;
`else
    assign go_done_c = last_c;
`endif

    // Sweep sequencer; status registers only change on an accepted start or a SAMPLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            vec_q     <= '0;
            idx_q     <= '0;
            pass_q    <= '0;
            set_cnt_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            flag_q    <= 1'b0;
            cnt_q     <= '0;
            ff_q      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    vec_q <= '0;
                    if (start) begin
                        cnt_q   <= '0;
                        flag_q  <= 1'b0;
                        ff_q    <= '0;
                        idx_q   <= '0;
                        pass_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= APPLY;
                    end
                end
                APPLY: begin
                    vec_q     <= idx_q;
                    set_cnt_q <= '0;
                    state_q   <= (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
                end
                SETTLE: begin
                    if (set_cnt_q == SET_W'(SET_LAST)) begin
                        state_q <= SAMPLE;
                    end else begin
                        set_cnt_q <= set_cnt_q + SET_W'(1);
                    end
                end
                SAMPLE: begin
                    if (mismatch_c) begin
                        flag_q <= 1'b1;
                        if (cnt_q != CNT_MAX) begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                        if (cnt_q == '0) begin
                            ff_q.vec  <= vec_q;
                            ff_q.resp <= resp_i;
                        end
                    end
                    if (go_done_c) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        vec_q   <= '0;
                        state_q <= DONE;
                    end else begin
                        // idx wraps 7->0 on its own; a wrap starts the next pass
                        idx_q <= idx_q + VEC_W'(1);
                        if (idx_q == LAST_IDX) begin
                            pass_q <= pass_q + PASS_W'(1);
                        end
                        state_q <= APPLY;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign vec_o           = vec_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign trojan_flag     = flag_q;
    assign mismatch_cnt    = cnt_q;
    assign first_fail_vec  = ff_q.vec;
    assign first_fail_resp = ff_q.resp;

endmodule

// File: tb/tb_cut_response_checker.sv
// Directed bench: four checker configurations driven by behavioural CUT models.
module tb_cut_response_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [3:0] start_v;
    int         cur;
    int         errors;
    int         checks;

    // u0: clean, SETTLE=2 | u1: H stuck at vec 5, PASSES=2 | u2: resp=F, CNT_W=2 | u3: clean, SETTLE=0
    logic [2:0] vec0, vec1, vec2, vec3;
    logic [3:0] resp0, resp1, resp2, resp3;
    logic       busy0, busy1, busy2, busy3;
    logic       done0, done1, done2, done3;
    logic       flag0, flag1, flag2, flag3;
    logic [7:0] cnt0, cnt1, cnt3;
    logic [1:0] cnt2;
    logic [2:0] ffv0, ffv1, ffv2, ffv3;
    logic [3:0] ffr0, ffr1, ffr2, ffr3;

    // Hand-derived CUT truth table {H,G,F,E}
    function automatic logic [3:0] cut_ok(input logic [2:0] v);
        case (v)
            3'd0: return 4'h4;
            3'd1: return 4'h2;
            3'd2: return 4'h4;
            3'd3: return 4'h2;
            3'd4: return 4'h6;
            3'd5: return 4'h2;
            3'd6: return 4'h7;
            default: return 4'hB;
        endcase
    endfunction

    assign resp0 = cut_ok(vec0);
    assign resp1 = (vec1 == 3'd5) ? (cut_ok(vec1) | 4'h8) : cut_ok(vec1);
    assign resp2 = 4'hF;
    assign resp3 = cut_ok(vec3);

    cut_response_checker #(.SETTLE_CYCLES(2), .PASSES(1), .CNT_W(8)) u0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .vec_o(vec0), .resp_i(resp0),
        .busy(busy0), .done(done0), .trojan_flag(flag0), .mismatch_cnt(cnt0),
        .first_fail_vec(ffv0), .first_fail_resp(ffr0));
    cut_response_checker #(.SETTLE_CYCLES(2), .PASSES(2), .CNT_W(8)) u1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .vec_o(vec1), .resp_i(resp1),
        .busy(busy1), .done(done1), .trojan_flag(flag1), .mismatch_cnt(cnt1),
        .first_fail_vec(ffv1), .first_fail_resp(ffr1));
    cut_response_checker #(.SETTLE_CYCLES(2), .PASSES(1), .CNT_W(2)) u2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .vec_o(vec2), .resp_i(resp2),
        .busy(busy2), .done(done2), .trojan_flag(flag2), .mismatch_cnt(cnt2),
        .first_fail_vec(ffv2), .first_fail_resp(ffr2));
    cut_response_checker #(.SETTLE_CYCLES(0), .PASSES(1), .CNT_W(8)) u3 (
        .clk(clk), .rst(rst), .start(start_v[3]), .vec_o(vec3), .resp_i(resp3),
        .busy(busy3), .done(done3), .trojan_flag(flag3), .mismatch_cnt(cnt3),
        .first_fail_vec(ffv3), .first_fail_resp(ffr3));

    logic       s_busy, s_done, s_flag;
    logic [7:0] s_cnt;
    logic [2:0] s_vec, s_ffv;
    logic [3:0] s_ffr;

    always_comb begin
        s_busy = busy0; s_done = done0; s_flag = flag0; s_cnt = cnt0;
        s_vec  = vec0;  s_ffv  = ffv0;  s_ffr  = ffr0;
        case (cur)
            1: begin
                s_busy = busy1; s_done = done1; s_flag = flag1; s_cnt = cnt1;
                s_vec  = vec1;  s_ffv  = ffv1;  s_ffr  = ffr1;
            end
            2: begin
                s_busy = busy2; s_done = done2; s_flag = flag2; s_cnt = {6'd0, cnt2};
                s_vec  = vec2;  s_ffv  = ffv2;  s_ffr  = ffr2;
            end
            3: begin
                s_busy = busy3; s_done = done3; s_flag = flag3; s_cnt = cnt3;
                s_vec  = vec3;  s_ffv  = ffv3;  s_ffr  = ffr3;
            end
            default: ;
        endcase
    end

    typedef struct {
        int         sel;
        bit         poke;
        int         done_cyc;
        logic [7:0] cnt;
        logic       flag;
        logic [2:0] ffv;
        logic [3:0] ffr;
    } run_t;

    run_t runs [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_run(input int r);
        int  per;
        int  dc;
        bit  seen;
        cur  = runs[r].sel;
        per  = (cur == 3) ? 2 : 4;
        dc   = 0;
        seen = 1'b0;
        @(negedge clk);
        start_v[cur] = 1'b1;
        for (int k = 1; k <= 200 && !seen; k++) begin
            @(posedge clk);
            #1;
            start_v[cur] = runs[r].poke && (k == 3 || k == 8);
            if (k == 1) begin
                check("busy_after_start", 32'(s_busy), 32'd1);
                check("cnt_cleared", 32'(s_cnt), 32'd0);
                check("flag_cleared", 32'(s_flag), 32'd0);
            end
            if ((cur == 0 || cur == 3) && (k % per == 0) && k < runs[r].done_cyc)
                check("vec_order", 32'(s_vec), 32'(k / per - 1));
            if (cur == 2 && k == 4) check("flag_before_sample", 32'(s_flag), 32'd0);
            if (cur == 2 && k == 5) check("flag_after_sample", 32'(s_flag), 32'd1);
            if (s_done) begin
                seen = 1'b1;
                dc   = k;
            end
        end
        check("done_cycle", 32'(dc), 32'(runs[r].done_cyc));
        check("mismatch_cnt", 32'(s_cnt), 32'(runs[r].cnt));
        check("trojan_flag", 32'(s_flag), 32'(runs[r].flag));
        check("first_fail_vec", 32'(s_ffv), 32'(runs[r].ffv));
        check("first_fail_resp", 32'(s_ffr), 32'(runs[r].ffr));
        check("busy_in_done", 32'(s_busy), 32'd0);
        start_v[cur] = runs[r].poke;
        @(posedge clk);
        #1;
        start_v[cur] = 1'b0;
        check("done_one_cycle", 32'(s_done), 32'd0);
        check("idle_not_busy", 32'(s_busy), 32'd0);
        @(posedge clk);
        #1;
        check("start_in_done_ignored", 32'(s_busy), 32'd0);
        check("status_stable", 32'(s_cnt), 32'(runs[r].cnt));
    endtask

    initial begin
        bit done_seen;
        errors  = 0;
        checks  = 0;
        cur     = 0;
        start_v = 4'b0000;
        rst     = 1'b1;

`ifdef CUT_STOP_ON_FAIL_EN
        runs[0] = '{sel: 0, poke: 1'b0, done_cyc: 33, cnt: 8'd0, flag: 1'b0, ffv: 3'd0, ffr: 4'h0};
        runs[1] = '{sel: 1, poke: 1'b0, done_cyc: 25, cnt: 8'd1, flag: 1'b1, ffv: 3'd5, ffr: 4'hA};
        runs[2] = '{sel: 2, poke: 1'b0, done_cyc: 5,  cnt: 8'd1, flag: 1'b1, ffv: 3'd0, ffr: 4'hF};
        runs[3] = '{sel: 3, poke: 1'b1, done_cyc: 17, cnt: 8'd0, flag: 1'b0, ffv: 3'd0, ffr: 4'h0};
`else
        runs[0] = '{sel: 0, poke: 1'b0, done_cyc: 33, cnt: 8'd0, flag: 1'b0, ffv: 3'd0, ffr: 4'h0};
        runs[1] = '{sel: 1, poke: 1'b0, done_cyc: 65, cnt: 8'd2, flag: 1'b1, ffv: 3'd5, ffr: 4'hA};
        runs[2] = '{sel: 2, poke: 1'b0, done_cyc: 33, cnt: 8'd3, flag: 1'b1, ffv: 3'd0, ffr: 4'hF};
        runs[3] = '{sel: 3, poke: 1'b1, done_cyc: 17, cnt: 8'd0, flag: 1'b0, ffv: 3'd0, ffr: 4'h0};
`endif

        repeat (3) @(posedge clk);
        #1;
        check("reset_u0", 32'({busy0, done0, flag0, cnt0, ffv0, ffr0, vec0}), 32'd0);
        check("reset_u1", 32'({busy1, done1, flag1, cnt1, ffv1, ffr1, vec1}), 32'd0);
        check("reset_u2", 32'({busy2, done2, flag2, cnt2, ffv2, ffr2, vec2}), 32'd0);
        check("reset_u3", 32'({busy3, done3, flag3, cnt3, ffv3, ffr3, vec3}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Second round confirms that a new start clears the previous run's status.
        for (int rep = 0; rep < 2; rep++)
            for (int r = 0; r < 4; r++)
                do_run(r);

        // Reset in the middle of vector 3's settle window.
        cur = 0;
        @(negedge clk);
        start_v[0] = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk);
            #1;
            start_v[0] = 1'b0;
        end
        check("mid_run_vec", 32'(vec0), 32'd3);
        check("mid_run_busy", 32'(busy0), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_outputs", 32'({busy0, done0, flag0, cnt0, ffv0, ffr0, vec0}), 32'd0);
        @(posedge clk);
        #1;
        check("reset_outputs_next", 32'({busy0, done0, flag0, cnt0, ffv0, ffr0, vec0}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done0 || busy0) done_seen = 1'b1;
        end
        check("no_done_after_abort", 32'(done_seen), 32'd0);
        do_run(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
